// File: rtl/eig_sched.sv
// Round-robin scheduler sharing one eig_core between N_CH requesters, with a
// watchdog that aborts core runs that never signal completion.
module eig_sched #(
    parameter int N_CH        = 4,
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [N_CH-1:0]          req_valid,
    input  logic [N_CH*32-1:0]       req_a0,
    input  logic [N_CH*32-1:0]       req_a1,
    output logic [N_CH-1:0]          req_ready,
    output logic                     core_start,
    output logic [31:0]              core_a0,
    output logic [31:0]              core_a1,
    input  logic                     core_done,
    input  logic [31:0]              core_kappa,
    input  logic [31:0]              core_inv_kappa,
    input  logic [2:0]               core_regime,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [$clog2(N_CH)-1:0]  res_ch,
    output logic [31:0]              res_kappa,
    output logic [31:0]              res_inv_kappa,
    output logic [2:0]               res_regime,
    output logic                     res_timeout,
    output logic [CNT_W-1:0]         timeout_cnt,
    output logic [1:0]               state_dbg
);

    localparam int PTR_W = $clog2(N_CH);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_OUT    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [31:0]        core_a0_q, core_a0_d;
    logic [31:0]        core_a1_q, core_a1_d;
    logic               res_valid_q, res_valid_d;
    logic [PTR_W-1:0]   res_ch_q, res_ch_d;
    logic [31:0]        res_kappa_q, res_kappa_d;
    logic [31:0]        res_inv_kappa_q, res_inv_kappa_d;
    logic [2:0]         res_regime_q, res_regime_d;
    logic               res_timeout_q, res_timeout_d;
    logic [CNT_W-1:0]   timeout_cnt_q, timeout_cnt_d;

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand_idx;
    int                 cand;

    // Scanning downward lets the lowest offset from rr_ptr win without a break.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= N_CH) cand = cand - N_CH;
            cand_idx = PTR_W'(cand);
            if (req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // valid/ready: a request moves in the cycle req_valid[i] && req_ready[i];
    // a result moves in the cycle res_valid && res_ready && ena.
    assign req_ready  = (rst_n && ena && state_q == S_IDLE && grant_found)
                        ? (N_CH'(1) << grant_idx) : '0;
    assign core_start = ena && (state_q == S_LAUNCH);

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        timer_d         = timer_q;
        core_a0_d       = core_a0_q;
        core_a1_d       = core_a1_q;
        res_valid_d     = res_valid_q;
        res_ch_d        = res_ch_q;
        res_kappa_d     = res_kappa_q;
        res_inv_kappa_d = res_inv_kappa_q;
        res_regime_d    = res_regime_q;
        res_timeout_d   = res_timeout_q;
        timeout_cnt_d   = timeout_cnt_q;
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        core_a0_d = req_a0[{grant_idx, 5'b0} +: 32];
                        core_a1_d = req_a1[{grant_idx, 5'b0} +: 32];
                        res_ch_d  = grant_idx;
                        rr_ptr_d  = (grant_idx == PTR_W'(N_CH - 1))
                                    ? '0 : grant_idx + PTR_W'(1);
                        state_d   = S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // A completion on the expiry cycle still counts as a real result.
                    if (core_done) begin
                        res_kappa_d     = core_kappa;
                        res_inv_kappa_d = core_inv_kappa;
                        res_regime_d    = core_regime;
                        res_timeout_d   = 1'b0;
                        res_valid_d     = 1'b1;
                        state_d         = S_OUT;
                    end else if (timer_q == TMR_LAST) begin
                        res_kappa_d     = '0;
                        res_inv_kappa_d = '0;
                        res_regime_d    = '0;
                        res_timeout_d   = 1'b1;
                        res_valid_d     = 1'b1;
                        if (timeout_cnt_q != '1) timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                        state_d         = S_OUT;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            rr_ptr_q        <= '0;
            timer_q         <= '0;
            core_a0_q       <= '0;
            core_a1_q       <= '0;
            res_valid_q     <= 1'b0;
            res_ch_q        <= '0;
            res_kappa_q     <= '0;
            res_inv_kappa_q <= '0;
            res_regime_q    <= '0;
            res_timeout_q   <= 1'b0;
            timeout_cnt_q   <= '0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            timer_q         <= timer_d;
            core_a0_q       <= core_a0_d;
            core_a1_q       <= core_a1_d;
            res_valid_q     <= res_valid_d;
            res_ch_q        <= res_ch_d;
            res_kappa_q     <= res_kappa_d;
            res_inv_kappa_q <= res_inv_kappa_d;
            res_regime_q    <= res_regime_d;
            res_timeout_q   <= res_timeout_d;
            timeout_cnt_q   <= timeout_cnt_d;
        end
    end

    assign core_a0       = core_a0_q;
    assign core_a1       = core_a1_q;
    assign res_valid     = res_valid_q;
    assign res_ch        = res_ch_q;
    assign res_kappa     = res_kappa_q;
    assign res_inv_kappa = res_inv_kappa_q;
    assign res_regime    = res_regime_q;
    assign res_timeout   = res_timeout_q;
    assign timeout_cnt   = timeout_cnt_q;
    assign state_dbg     = state_q;

endmodule
